// File: rtl/grav_pkg.sv
// rtl/grav_pkg.sv - shared constants, state encoding and pair table for the gravity sequencer/datapath
package grav_pkg;

  // Ordered planet pairs visited per sweep (AB AC BA BC CA CB)
  localparam int NUM_PAIRS = 6;
  localparam int LAST_PAIR = NUM_PAIRS - 1;

  // Width of the relation counter and of a planet index
  localparam int REL_W = 3;
  localparam int IDX_W = 2;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POS   = 2'd1,
    ST_SWEEP = 2'd2
  } seq_state_t;

  // Planet indices
  localparam logic [IDX_W-1:0] PLANET_A = 2'd0;
  localparam logic [IDX_W-1:0] PLANET_B = 2'd1;
  localparam logic [IDX_W-1:0] PLANET_C = 2'd2;

  // Relation numbers, in sweep order
  localparam logic [REL_W-1:0] PAIR_AB = 3'd0;
  localparam logic [REL_W-1:0] PAIR_AC = 3'd1;
  localparam logic [REL_W-1:0] PAIR_BA = 3'd2;
  localparam logic [REL_W-1:0] PAIR_BC = 3'd3;
  localparam logic [REL_W-1:0] PAIR_CA = 3'd4;
  localparam logic [REL_W-1:0] PAIR_CB = 3'd5;

  // Accelerated planet p and attracting planet q of one relation
  typedef struct packed {
    logic [IDX_W-1:0] p;
    logic [IDX_W-1:0] q;
  } pair_t;

  // Relation number -> (p, q); unused codes map to (A, A)
  function automatic pair_t pair_lookup(input logic [REL_W-1:0] rel);
    pair_t pr;
    case (rel)
      PAIR_AB: pr = '{p: PLANET_A, q: PLANET_B};
      PAIR_AC: pr = '{p: PLANET_A, q: PLANET_C};
      PAIR_BA: pr = '{p: PLANET_B, q: PLANET_A};
      PAIR_BC: pr = '{p: PLANET_B, q: PLANET_C};
      PAIR_CA: pr = '{p: PLANET_C, q: PLANET_A};
      PAIR_CB: pr = '{p: PLANET_C, q: PLANET_B};
      default: pr = '{p: PLANET_A, q: PLANET_A};
    endcase
    return pr;
  endfunction

endpackage

// File: rtl/pair_index_decoder.sv
// rtl/pair_index_decoder.sv - relation number to (accelerated, attracting) planet index decoder
module pair_index_decoder
  import grav_pkg::*;
(
  input  logic [REL_W-1:0] i_rel,
  output logic [IDX_W-1:0] o_p_idx,
  output logic [IDX_W-1:0] o_q_idx
);

  pair_t w_pair;

  // Pure table lookup; shared with the gravity datapath so both sides agree on pair order
  always_comb begin
    w_pair  = pair_lookup(i_rel);
    o_p_idx = w_pair.p;
    o_q_idx = w_pair.q;
  end

endmodule

// File: rtl/gravity_sequencer.sv
// rtl/gravity_sequencer.sv - frame scheduler for the three-body datapath; GRAV_SEQ_SINGLE_STEP_EN adds a paused single-step button
module gravity_sequencer #(
  parameter int NUM_PAIRS = 6,
  parameter int DIV_W     = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_frame_tick,
  input  logic             i_blanking,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_speed,
  input  logic             i_step_btn,
  output logic             o_pos_update,
  output logic             o_vel_step,
  output logic [1:0]       o_p_idx,
  output logic [1:0]       o_q_idx,
  output logic             o_axis,
  output logic             o_busy,
  output logic             o_overrun
);

  import grav_pkg::*;

  localparam logic [REL_W-1:0] LAST_REL = REL_W'(NUM_PAIRS - 1);

  seq_state_t       r_state;
  logic [REL_W-1:0] r_rel;
  logic             r_axis;
  logic             r_pos_update;
  logic             r_overrun;
  logic [DIV_W-1:0] r_div_cnt;

  logic             w_idle;
  logic             w_sweep;
  logic             w_tick_idle;
  logic             w_div_zero;
  logic             w_fire_div;
  logic             w_fire;
  logic             w_vel_step;
  logic [IDX_W-1:0] w_p_idx;
  logic [IDX_W-1:0] w_q_idx;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_sweep     = (r_state == ST_SWEEP);
  assign w_tick_idle = i_frame_tick & w_idle;
  assign w_div_zero  = (r_div_cnt == '0);
  assign w_fire_div  = w_tick_idle & i_run & w_div_zero;
  // Micro-steps only advance while the beam is blanked, so the datapath never races the display
  assign w_vel_step  = w_sweep & i_blanking;

`ifdef GRAV_SEQ_SINGLE_STEP_EN
  logic r_btn_meta;
  logic r_btn_sync;
  logic r_btn_prev;
  logic r_pending;
  logic w_btn_rise;

  // Two-flop synchronizer for the asynchronous button, plus one delay flop for edge detection
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_meta <= i_step_btn;
      r_btn_sync <= r_btn_meta;
      r_btn_prev <= r_btn_sync;
    end
  end

  assign w_btn_rise = r_btn_sync & ~r_btn_prev;

  // Hold a paused single-step request until an idle frame tick consumes it; presses while running are ignored
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pending <= 1'b0;
    end else if (w_btn_rise && !i_run) begin
      r_pending <= 1'b1;
    end else if (w_fire) begin
      r_pending <= 1'b0;
    end
  end

  assign w_fire = w_fire_div | (w_tick_idle & r_pending);
`else
  logic w_unused_step_btn;
  assign w_unused_step_btn = i_step_btn;
  assign w_fire            = w_fire_div;
`endif

  // Frame divider: reload on every fire, count down on idle ticks while running, hold while paused
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div_cnt <= '0;
    end else if (w_fire) begin
      r_div_cnt <= i_speed;
    end else if (w_tick_idle && i_run && !w_div_zero) begin
      r_div_cnt <= r_div_cnt - 1'b1;
    end
  end

  // Main sequence: one position-update cycle, then the ordered pair/axis sweep
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_rel        <= '0;
      r_axis       <= 1'b0;
      r_pos_update <= 1'b0;
    end else begin
      r_pos_update <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_state      <= ST_POS;
            r_pos_update <= 1'b1;
          end
        end
        ST_POS: begin
          r_state <= ST_SWEEP;
          r_rel   <= '0;
          r_axis  <= 1'b0;
        end
        ST_SWEEP: begin
          if (w_vel_step) begin
            if (!r_axis) begin
              r_axis <= 1'b1;
            end else begin
              r_axis <= 1'b0;
              if (r_rel == LAST_REL) begin
                r_rel   <= '0;
                r_state <= ST_IDLE;
              end else begin
                r_rel <= r_rel + 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rel   <= '0;
          r_axis  <= 1'b0;
        end
      endcase
    end
  end

  // A frame tick that lands mid-sequence means the physics could not keep up; latch it until reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overrun <= 1'b0;
    end else if (i_frame_tick && !w_idle) begin
      r_overrun <= 1'b1;
    end
  end

  pair_index_decoder u_pair_dec (
    .i_rel   (r_rel),
    .o_p_idx (w_p_idx),
    .o_q_idx (w_q_idx)
  );

  // Indices are only meaningful during the sweep; park them at A outside it
  assign o_p_idx      = w_sweep ? w_p_idx : PLANET_A;
  assign o_q_idx      = w_sweep ? w_q_idx : PLANET_A;
  assign o_axis       = r_axis;
  assign o_pos_update = r_pos_update;
  assign o_vel_step   = w_vel_step;
  assign o_busy       = ~w_idle;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_gravity_sequencer.sv
// tb/tb_gravity_sequencer.sv - self-checking bench for gravity_sequencer
module tb_gravity_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       blank;
  logic       run;
  logic       btn;
  logic [3:0] spd;
  logic       pos, vel, ax, busy, ovr;
  logic [1:0] p, q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gravity_sequencer #(.NUM_PAIRS(6), .DIV_W(4)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_frame_tick (tick),
    .i_blanking   (blank),
    .i_run        (run),
    .i_speed      (spd),
    .i_step_btn   (btn),
    .o_pos_update (pos),
    .o_vel_step   (vel),
    .o_p_idx      (p),
    .o_q_idx      (q),
    .o_axis       (ax),
    .o_busy       (busy),
    .o_overrun    (ovr)
  );

  // Reference model: a frame either idles, does its position cycle, or works through step k of 12
  int  tp [6] = '{0, 0, 1, 1, 2, 2};
  int  tq [6] = '{1, 2, 0, 2, 0, 1};
  int  m_div;
  bit  m_pos, m_sweep, m_over;
  int  m_k;

  int n_pos, n_vel, n_busy;
  logic [8:0] s_got;

  function automatic logic [8:0] model_out(input bit b);
    logic [1:0] ep, eq;
    logic ea;
    ep = 2'd0; eq = 2'd0; ea = 1'b0;
    if (m_sweep) begin
      ep = 2'(tp[m_k / 2]);
      eq = 2'(tq[m_k / 2]);
      ea = 1'(m_k % 2);
    end
    return {m_pos, m_sweep & b, ep, eq, ea, m_pos | m_sweep, m_over};
  endfunction

  task automatic model_clear();
    m_div = 0; m_pos = 0; m_sweep = 0; m_over = 0; m_k = 0;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare just after, then advance the model on the posedge
  task automatic cyc(input bit t, input bit b, input bit r, input logic [3:0] s, input bit chk);
    logic [8:0] exp;
    bit idle;
    @(negedge clk);
    tick = t; blank = b; run = r; spd = s;
    #1;
    s_got = {pos, vel, p, q, ax, busy, ovr};
    exp   = model_out(b);
    if (chk) begin
      total++;
      if (s_got !== exp) begin
        bad++;
        $display("FAIL model_cmp t=%0t got=%b expected=%b", $time, s_got, exp);
      end
    end
    if (pos)  n_pos++;
    if (vel)  n_vel++;
    if (busy) n_busy++;
    @(posedge clk);
    idle = !m_pos && !m_sweep;
    if (t && !idle) m_over = 1;
    if (m_sweep && b) begin
      m_k++;
      if (m_k == 12) m_sweep = 0;
    end
    if (m_pos) begin
      m_pos = 0; m_sweep = 1; m_k = 0;
    end else if (idle && t && r) begin
      if (m_div == 0) begin
        m_pos = 1; m_div = int'(s);
      end else begin
        m_div--;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; tick = 0; blank = 0; run = 0; btn = 0; spd = 0;
    #1;
    check("reset_outs", int'({pos, vel, p, q, ax, busy, ovr}), 0);
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  task automatic clr_cnt();
    n_pos = 0; n_vel = 0; n_busy = 0;
  endtask

  typedef struct {
    bit         t;
    logic [7:0] exp;
  } vec_t;

  function automatic logic [7:0] mk(input bit ps, input bit vs, input int pi, input int qi, input bit a, input bit bz);
    return {ps, vs, 2'(pi), 2'(qi), a, bz};
  endfunction

  vec_t vt [15];
  int   seq_p [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
  int   seq_q [12] = '{1, 1, 2, 2, 0, 0, 2, 2, 0, 0, 1, 1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1; tick = 0; blank = 0; run = 0; btn = 0; spd = 0;
    model_clear();
    clr_cnt();

    // Test 1 vectors: tick, position strobe, 12 ordered steps, idle
    vt[0]  = '{t: 1'b1, exp: mk(0, 0, 0, 0, 0, 0)};
    vt[1]  = '{t: 1'b0, exp: mk(1, 0, 0, 0, 0, 1)};
    for (int i = 0; i < 12; i++)
      vt[2 + i] = '{t: 1'b0, exp: mk(0, 1, seq_p[i], seq_q[i], 1'(i % 2), 1)};
    vt[14] = '{t: 1'b0, exp: mk(0, 0, 0, 0, 0, 0)};

    do_reset();

    // Test 1: table-driven single sweep with continuous blanking
    for (int i = 0; i < 15; i++) begin
      cyc(vt[i].t, 1, 1, 4'd0, 1);
      check($sformatf("vec%0d", i), int'(s_got[8:1]), int'(vt[i].exp));
    end

    // Test 2: divider speed=2, nine ticks 100 cycles apart
    clr_cnt();
    for (int k = 0; k < 9; k++) begin
      cyc(1, 1, 1, 4'd2, 1);
      for (int i = 0; i < 99; i++) cyc(0, 1, 1, 4'd2, 1);
    end
    check("div_pos_cnt", n_pos, 3);
    check("div_vel_cnt", n_vel, 36);

    // Test 3: blanking one high in four stretches the sweep
    clr_cnt();
    for (int c = 0; c < 80; c++) cyc(c == 0, (c % 4) == 0, 1, 4'd0, 1);
    check("gap_vel_cnt", n_vel, 12);
    check("gap_busy_len", n_busy, 48);

    // Test 4: tick while busy sets sticky overrun, no restart
    clr_cnt();
    for (int c = 0; c < 26; c++) cyc(c == 0 || c == 20, 0, 1, 4'd0, 1);
    check("ovr_pos_cnt", n_pos, 1);
    check("ovr_set", int'(ovr), 1);
    for (int c = 0; c < 20; c++) cyc(0, 1, 1, 4'd0, 1);
    check("ovr_vel_cnt", n_vel, 12);
    check("ovr_sticky", int'(ovr), 1);

    // Test 5: paused ticks leave the divider untouched
    do_reset();
    cyc(1, 1, 1, 4'd2, 1);
    for (int c = 0; c < 20; c++) cyc(0, 1, 1, 4'd2, 1);
    clr_cnt();
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 4'd2, 1);
      for (int c = 0; c < 4; c++) cyc(0, 1, 0, 4'd2, 1);
    end
    check("pause_pos_cnt", n_pos, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, 1, 4'd2, 1);
      for (int c = 0; c < 4; c++) cyc(0, 1, 1, 4'd2, 1);
    end
    check("resume_countdown", n_pos, 0);
    cyc(1, 1, 1, 4'd2, 1);
    for (int c = 0; c < 20; c++) cyc(0, 1, 1, 4'd2, 1);
    check("resume_fire", n_pos, 1);

    // Test 6: asynchronous reset after the fifth micro-step
    do_reset();
    clr_cnt();
    cnt = 0;
    cyc(1, 1, 1, 4'd0, 1);
    while (n_vel < 5 && cnt < 50) begin
      cyc(0, 1, 1, 4'd0, 1);
      cnt++;
    end
    check("reach_step5", n_vel, 5);
    #2 rst = 1;
    #1 check("async_rst_outs", int'({pos, vel, p, q, ax, busy, ovr}), 0);
    @(negedge clk);
    @(negedge clk);
    #1 check("held_rst_outs", int'({pos, vel, p, q, ax, busy, ovr}), 0);
    rst = 0;
    model_clear();
    cyc(1, 1, 1, 4'd0, 1);
    cyc(0, 1, 1, 4'd0, 1);
    cyc(0, 1, 1, 4'd0, 1);
    check("restart_first_step", int'(s_got[7:2]), int'(6'b1_00_01_0));
    for (int c = 0; c < 15; c++) cyc(0, 1, 1, 4'd0, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) spd = 4'($urandom_range(0, 3));
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) != 0, spd, 1);
    end

    // Single-step button while paused
    do_reset();
    for (int c = 0; c < 3; c++) begin btn = 1; cyc(0, 1, 0, 4'd0, 0); end
    btn = 0;
    for (int c = 0; c < 5; c++) cyc(0, 1, 0, 4'd0, 0);
    clr_cnt();
    cyc(1, 1, 0, 4'd0, 0);
    for (int c = 0; c < 20; c++) cyc(0, 1, 0, 4'd0, 0);
`ifdef GRAV_SEQ_SINGLE_STEP_EN
    check("step_pos_cnt", n_pos, 1);
    check("step_vel_cnt", n_vel, 12);
`else
    check("step_pos_cnt", n_pos, 0);
    check("step_vel_cnt", n_vel, 0);
`endif
    clr_cnt();
    cyc(1, 1, 0, 4'd0, 0);
    for (int c = 0; c < 20; c++) cyc(0, 1, 0, 4'd0, 0);
    check("step_once_only", n_pos, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
